// File: rtl/xif_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xif_pkg
// Description : Shared types and constants for the MemSplit32 expansion
//               interface responder.
// Revision    : 1.0 - initial release
// ============================================================================
package xif_pkg;

    localparam int MEMSPLIT_DW  = 32;
    localparam int MEMSPLIT_BEW = 4;

    // Request-accept FSM states of the responder.
    typedef enum logic [0:0] {
        XS_WAIT  = 1'b0,
        XS_READY = 1'b1
    } xif_resp_state_e;

    // One stage of the read-response pipeline.
    typedef struct packed {
        logic        vld;
        logic [31:0] data;
    } rd_stage_t;

endpackage
`default_nettype wire

// File: rtl/xif_memsplit32_if.sv
`default_nettype none
// ============================================================================
// Module      : MemSplit32
// Description : Split request/response memory interface (32-bit data,
//               4 byte enables). Master drives the request, slave acks
//               and returns in-order read responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface MemSplit32;
    import xif_pkg::*;

    logic                    req;
    logic                    ack;
    logic                    we;
    logic [31:0]             addr;
    logic [MEMSPLIT_BEW-1:0] be;
    logic [MEMSPLIT_DW-1:0]  wdata;
    logic                    resp;
    logic [MEMSPLIT_DW-1:0]  rdata;

    modport Slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
    modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);

endinterface
`default_nettype wire

// File: rtl/xif_mem_responder_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : xif_rd_pipe
// Description : RD_LATENCY-deep valid/data shift pipeline with synchronous
//               clear. Data of an invalid stage is held at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_rd_pipe
    import xif_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic      clk,
    input  logic      i_clr,
    input  rd_stage_t i_stage,
    output rd_stage_t o_stage
);

    rd_stage_t r_stage [RD_LATENCY];

    // Shift stages forward every cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0].vld  <= i_stage.vld;
            r_stage[0].data <= i_stage.vld ? i_stage.data : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_stage = r_stage[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/xif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_responder
// Description : MemSplit32 slave endpoint. Word-addressed local RAM behind a
//               request-accept FSM with programmable wait states, a fixed
//               latency read pipeline and an outstanding-read credit limit.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_mem_responder
    import xif_pkg::*;
#(
    parameter int MEM_SIZE        = 1024,
    parameter int RD_LATENCY      = 2,
    parameter int WAIT_STATES     = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    MemSplit32.Slave host
);

    localparam int c_IDX_W = $clog2(MEM_SIZE);
    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] c_CNT_LAST =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
    // With no wait states the FSM never leaves READY.
    localparam xif_resp_state_e c_RST_STATE =
        (WAIT_STATES == 0) ? XS_READY : XS_WAIT;

    xif_resp_state_e        r_state;
    xif_resp_state_e        w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [c_OUT_W-1:0]     r_outstanding;
    logic                   w_credit_ok;
    logic                   w_ack;
    logic                   w_rd_hs;
    logic                   w_wr_hs;
    logic [c_IDX_W-1:0]     w_idx;
    logic [MEMSPLIT_DW-1:0] r_mem [MEM_SIZE];
    rd_stage_t              w_pipe_in;
    rd_stage_t              w_pipe_out;
    logic                   w_unused_addr;

    // Upper address bits and the byte offset are ignored, so addresses alias.
    assign w_idx         = host.addr[c_IDX_W+1:2];
    assign w_unused_addr = ^{host.addr[31:c_IDX_W+2], host.addr[1:0]};

    // A response leaving the pipe frees its credit in the same cycle.
    assign w_credit_ok = (r_outstanding < c_MAX_OUT) || w_pipe_out.vld;
    assign w_rd_hs     = w_ack && !host.we;
    assign w_wr_hs     = w_ack &&  host.we;

    // Next-state and ack: count held-req cycles in WAIT, accept in READY.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack       = 1'b0;
        case (r_state)
            XS_WAIT: begin
                if (host.req) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = XS_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            XS_READY: begin
                w_ack = host.req && w_credit_ok && !rst_i;
                if (w_ack && (WAIT_STATES > 0)) begin
                    w_state_nxt = XS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_RST_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and wait-state counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outstanding-read counter: +1 on read accept, -1 on response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_hs, w_pipe_out.vld})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Credit accounting must never exceed the configured limit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (r_outstanding <= c_MAX_OUT);
        end
    end
`endif

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_hs) begin
            for (int i = 0; i < MEMSPLIT_BEW; i++) begin
                if (host.be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= host.wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_pipe_in.vld  = w_rd_hs;
    assign w_pipe_in.data = w_rd_hs ? r_mem[w_idx] : '0;

    xif_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk_i),
        .i_clr   (rst_i),
        .i_stage (w_pipe_in),
        .o_stage (w_pipe_out)
    );

    assign host.ack   = w_ack;
    assign host.resp  = w_pipe_out.vld;
    assign host.rdata = w_pipe_out.vld ? w_pipe_out.data : '0;

endmodule
`default_nettype wire

// File: tb/tb_xif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_mem_responder
// Description : Self-checking bench for xif_mem_responder. Three DUTs with
//               different latency / wait-state settings are driven with
//               directed and random MemSplit32 traffic and compared against
//               a transaction-level reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_mem_responder;

    localparam int NDUT = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  ab;   // drop req after this many cycles if not acked (0 = hold)
    } op_t;

    logic clk;
    logic rst;
    logic rst_nxt;
    logic rst_last;

    MemSplit32 bus0 ();
    MemSplit32 bus1 ();
    MemSplit32 bus2 ();

    logic        d_req   [NDUT];
    logic        d_we    [NDUT];
    logic [31:0] d_addr  [NDUT];
    logic [31:0] d_wdata [NDUT];
    logic [3:0]  d_be    [NDUT];
    logic        o_ack   [NDUT];
    logic        o_resp  [NDUT];
    logic [31:0] o_rdata [NDUT];

    assign bus0.req = d_req[0]; assign bus0.we = d_we[0]; assign bus0.addr = d_addr[0];
    assign bus0.be  = d_be[0];  assign bus0.wdata = d_wdata[0];
    assign bus1.req = d_req[1]; assign bus1.we = d_we[1]; assign bus1.addr = d_addr[1];
    assign bus1.be  = d_be[1];  assign bus1.wdata = d_wdata[1];
    assign bus2.req = d_req[2]; assign bus2.we = d_we[2]; assign bus2.addr = d_addr[2];
    assign bus2.be  = d_be[2];  assign bus2.wdata = d_wdata[2];
    assign o_ack[0] = bus0.ack; assign o_resp[0] = bus0.resp; assign o_rdata[0] = bus0.rdata;
    assign o_ack[1] = bus1.ack; assign o_resp[1] = bus1.resp; assign o_rdata[1] = bus1.rdata;
    assign o_ack[2] = bus2.ack; assign o_resp[2] = bus2.resp; assign o_rdata[2] = bus2.rdata;

    xif_mem_responder #(.MEM_SIZE(1024), .RD_LATENCY(2), .WAIT_STATES(0), .MAX_OUTSTANDING(2))
        u_dut0 (.clk_i(clk), .rst_i(rst), .host(bus0));
    xif_mem_responder #(.MEM_SIZE(1024), .RD_LATENCY(4), .WAIT_STATES(0), .MAX_OUTSTANDING(2))
        u_dut1 (.clk_i(clk), .rst_i(rst), .host(bus1));
    xif_mem_responder #(.MEM_SIZE(1024), .RD_LATENCY(2), .WAIT_STATES(3), .MAX_OUTSTANDING(2))
        u_dut2 (.clk_i(clk), .rst_i(rst), .host(bus2));

    function automatic int rl_of(int k);
        return (k == 1) ? 4 : 2;
    endfunction
    function automatic int ws_of(int k);
        return (k == 2) ? 3 : 0;
    endfunction
    function automatic int mo_of(int k);
        return 2;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] mmem   [NDUT][1024];
    int          hold   [NDUT];      // cycles req has been shown since rise / last accept
    int          outst  [NDUT];      // reads accepted, response not yet seen
    bit          due_v  [NDUT][16];  // response expected in cycle (slot)
    logic [31:0] due_d  [NDUT][16];
    bit          e_hs   [NDUT];
    bit          e_resp [NDUT];
    logic [31:0] resp_log [NDUT][$];
    int          cyc = 0;

    // ---------------- driver state ----------------
    op_t opq    [NDUT][$];
    bit  act    [NDUT];
    int  held   [NDUT];
    int  ab_lim [NDUT];
    bit  rnd_en = 1'b0;

    task automatic push_op(int k, logic we, logic [31:0] addr, logic [31:0] wdata,
                           logic [3:0] be, logic [3:0] ab);
        op_t op;
        op.we = we; op.addr = addr; op.wdata = wdata; op.be = be; op.ab = ab;
        opq[k].push_back(op);
    endtask

    // Advance the model by one clock edge using the cycle just ended.
    task automatic model_edge(int k);
        int slot;
        int idx;
        slot = cyc % 16;
        idx  = int'(d_addr[k][11:2]);
        if (rst) begin
            outst[k] = 0;
            hold[k]  = 0;
            for (int s = 0; s < 16; s++) due_v[k][s] = 1'b0;
        end else begin
            if (e_resp[k]) begin
                due_v[k][slot] = 1'b0;
                outst[k]--;
            end
            if (e_hs[k]) begin
                if (d_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (d_be[k][b]) mmem[k][idx][8*b +: 8] = d_wdata[k][8*b +: 8];
                end else begin
                    due_v[k][(cyc + rl_of(k)) % 16] = 1'b1;
                    due_d[k][(cyc + rl_of(k)) % 16] = mmem[k][idx];
                    outst[k]++;
                end
                hold[k] = 0;
            end else if (d_req[k]) begin
                hold[k]++;
            end else begin
                hold[k] = 0;
            end
        end
    endtask

    task automatic drive(int k);
        bit  drop;
        op_t op;
        drop = 1'b0;
        if (act[k]) begin
            if (e_hs[k]) begin
                act[k] = 1'b0;
            end else begin
                held[k]++;
                if (ab_lim[k] > 0 && held[k] >= ab_lim[k]) begin
                    act[k] = 1'b0;
                    drop   = 1'b1;
                end
            end
        end
        if (!act[k] && !drop) begin
            if (opq[k].size() > 0) begin
                op = opq[k].pop_front();
                act[k] = 1'b1;
            end else if (rnd_en && $urandom_range(0, 3) != 0) begin
                op.we    = 1'($urandom_range(0, 1));
                op.addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                           | 32'($urandom_range(0, 3));
                op.wdata = $urandom;
                op.be    = 4'($urandom_range(0, 15));
                op.ab    = 4'd0;
                if (ws_of(k) >= 2 && $urandom_range(0, 7) == 0)
                    op.ab = 4'($urandom_range(1, ws_of(k) - 1));
                act[k] = 1'b1;
            end
            if (act[k]) begin
                d_we[k] = op.we; d_addr[k] = op.addr; d_wdata[k] = op.wdata;
                d_be[k] = op.be; ab_lim[k] = int'(op.ab); held[k] = 0;
            end
        end
        d_req[k] = act[k];
    endtask

    task automatic check_cyc(int k);
        int slot;
        bit exp_ack;
        slot = cyc % 16;
        e_hs[k]   = 1'b0;
        e_resp[k] = 1'b0;
        if (rst) begin
            check_val($sformatf("d%0d_ack_in_reset", k), 32'(o_ack[k]), 32'd0);
            if (rst_last) begin
                check_val($sformatf("d%0d_resp_in_reset", k), 32'(o_resp[k]), 32'd0);
                check_val($sformatf("d%0d_rdata_in_reset", k), o_rdata[k], 32'd0);
            end
        end else begin
            e_resp[k] = due_v[k][slot];
            exp_ack = d_req[k] && (hold[k] >= ws_of(k)) &&
                      ((outst[k] < mo_of(k)) || e_resp[k]);
            check_val($sformatf("d%0d_ack@%0d", k, cyc), 32'(o_ack[k]), 32'(exp_ack));
            check_val($sformatf("d%0d_resp@%0d", k, cyc), 32'(o_resp[k]), 32'(e_resp[k]));
            check_val($sformatf("d%0d_rdata@%0d", k, cyc), o_rdata[k],
                      e_resp[k] ? due_d[k][slot] : 32'd0);
            if (o_resp[k]) resp_log[k].push_back(o_rdata[k]);
            e_hs[k] = exp_ack;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_edge(k);
        rst_last = rst;
        cyc++;
        #1;
        rst = rst_nxt;
        for (int k = 0; k < NDUT; k++) drive(k);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check_cyc(k);
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NDUT; k++)
            if (act[k] || opq[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_idle(string tag, int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        if (!all_idle()) check_val({tag, "_timeout"}, 32'd1, 32'd0);
        repeat (12) step();
    endtask

    task automatic check_log(int k, string tag, logic [31:0] exp [$]);
        check_val({tag, "_count"}, 32'(resp_log[k].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < resp_log[k].size(); i++)
            check_val($sformatf("%s_%0d", tag, i), resp_log[k][i], exp[i]);
        resp_log[k].delete();
    endtask

    initial begin
        int  left;
        int  n;
        logic [31:0] exp [$];
        rst = 1'b1; rst_nxt = 1'b1; rst_last = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
            act[k] = 1'b0; held[k] = 0; ab_lim[k] = 0; hold[k] = 0; outst[k] = 0;
            e_hs[k] = 1'b0; e_resp[k] = 1'b0;
            for (int s = 0; s < 16; s++) due_v[k][s] = 1'b0;
        end
        repeat (3) step();
        rst_nxt = 1'b0;

        // Initialise the random working set (words 0..15) on every DUT.
        for (int k = 0; k < NDUT; k++)
            for (int w = 0; w < 16; w++)
                push_op(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 4'd0);

        // DUT0: full write + read, byte-lane merge, address alias.
        push_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0);
        push_op(0, 1'b0, 32'h10, 32'h0, 4'h0, 4'd0);
        push_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 4'd0);
        push_op(0, 1'b1, 32'h20, 32'hAA000055, 4'b1001, 4'd0);
        push_op(0, 1'b0, 32'h20, 32'h0, 4'h0, 4'd0);
        push_op(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 4'd0);
        push_op(0, 1'b0, 32'h0, 32'h0, 4'h0, 4'd0);
        // DUT1: credit stall on back-to-back reads.
        for (int w = 0; w < 4; w++) push_op(1, 1'b1, 32'(w * 4), 32'(w + 1), 4'hF, 4'd0);
        for (int w = 0; w < 4; w++) push_op(1, 1'b0, 32'(w * 4), 32'h0, 4'h0, 4'd0);
        // DUT2: wait states, abandoned request must not write.
        push_op(2, 1'b1, 32'h40, 32'hBAD0BAD0, 4'hF, 4'd1);
        push_op(2, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 4'd0);
        push_op(2, 1'b0, 32'h40, 32'h0, 4'h0, 4'd0);
        run_until_idle("directed", 400);

        exp = '{32'hDEADBEEF, 32'hAA223355, 32'h5A5A5A5A};
        check_log(0, "d0_directed", exp);
        exp = '{32'd1, 32'd2, 32'd3, 32'd4};
        check_log(1, "d1_credit", exp);
        exp = '{32'h0BADF00D};
        check_log(2, "d2_waitst", exp);

        // Random traffic with occasional resets.
        rnd_en = 1'b1;
        left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (left > 0) begin
                rst_nxt = 1'b1;
                left--;
            end else begin
                rst_nxt = 1'b0;
                if ($urandom_range(0, 299) == 0) left = 2;
            end
            step();
        end
        rst_nxt = 1'b0;
        rnd_en  = 1'b0;
        run_until_idle("random", 200);
        for (int k = 0; k < NDUT; k++) resp_log[k].delete();

        // Reset drops an in-flight read but preserves RAM contents.
        push_op(0, 1'b1, 32'h40, 32'h13579BDF, 4'hF, 4'd0);
        push_op(0, 1'b0, 32'h40, 32'h0, 4'h0, 4'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!(e_hs[0] && !d_we[0]) && n < 50);
        if (!(e_hs[0] && !d_we[0])) check_val("rst_read_hs_timeout", 32'd1, 32'd0);
        rst_nxt = 1'b1;
        repeat (2) step();
        rst_nxt = 1'b0;
        repeat (6) step();
        exp = '{};
        check_log(0, "d0_dropped_read", exp);
        push_op(0, 1'b0, 32'h40, 32'h0, 4'h0, 4'd0);
        run_until_idle("post_reset", 50);
        exp = '{32'h13579BDF};
        check_log(0, "d0_preserved", exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
